lc3_pipe_ctrl: RTL and testbench
================================

# lc3_pipe_ctrl

Pipeline controller for the LC-3 five-stage datapath (fetch, decode, execute, memaccess, writeback). It sequences the stage enables after reset and parks the pipeline while memaccess runs LD/LDR/ST/STR/LDI/STI against data memory. It also flushes two stages on a taken branch and produces the execute-stage operand bypass selects. It sits beside the datapath and drives the control inputs of every stage; it is the DUT behind the control agent pair.

## Interface
- No parameters. Widths are fixed by the LC-3 ISA.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `complete_instr` in 1: instruction memory returned valid data this cycle.
- `complete_data` in 1: data memory access finished this cycle.
- `IR` in 16: instruction in decode.
- `IR_Exec` in 16: instruction in execute.
- `NZP` in 3: branch condition field latched with IR_Exec.
- `psr` in 3: current N/Z/P flags.
- `enable_updatePC`, `enable_fetch`, `enable_decode`, `enable_execute`, `enable_writeback` out 1 each: stage enables, registered.
- `mem_state` out 2: 0 = read, 1 = write, 2 = indirect address read, 3 = idle. Registered.
- `br_taken` out 1: combinational redirect of the PC.
- `bypass_alu_1`, `bypass_alu_2` out 1 each: combinational; forward the execute result to SR1 / SR2 in decode.

## Operation
- Opcode decode on `IR_Exec[15:12]`:
  - Load: LD = 0010, LDR = 0110, LDI = 1010.
  - Store: ST = 0011, STR = 0111, STI = 1011.
  - Branch: BR = 0000, JMP = 1100.
  - ALU: ADD = 0001, AND = 0101, NOT = 1001, LEA = 1110.
- FSM states: STARTUP, RUN, MEM_IND, MEM_RW, FLUSH.
- STARTUP:
  - A 2-bit ramp counter enables the stages in order.
  - Ramp cycle 1: updatePC and fetch.
  - Ramp cycle 2: adds decode.
  - Ramp cycle 3: adds execute.
  - Ramp cycle 4: adds writeback and moves to RUN.
- RUN:
  - All enables are 1 while `complete_instr` = 1.
  - If `complete_instr` = 0, all enables are 0 and the state holds.
- Memory entry (from RUN, with `enable_execute` = 1 and IR_Exec a memory op):
  - All five enables go to 0.
  - LDI/STI enter MEM_IND with `mem_state` = 2.
  - Other loads enter MEM_RW with `mem_state` = 0.
  - Other stores enter MEM_RW with `mem_state` = 1.
- MEM_IND: on `complete_data`, move to MEM_RW with `mem_state` 0 (LDI) or 1 (STI).
- MEM_RW:
  - On `complete_data`, return to RUN with `mem_state` = 3.
  - All enables return to 1 on that edge; `enable_writeback` = 1 only for loads, 0 for stores.
- Branch (from RUN, IR_Exec a branch):
  - `br_taken` = (BR and `|(NZP & psr)`) or JMP.
  - On the edge where `br_taken` is taken, enter FLUSH.
  - FLUSH lasts 2 cycles: `enable_decode` = `enable_execute` = `enable_writeback` = 0; `enable_fetch` = `enable_updatePC` = 1.
  - After 2 cycles, return to RUN.
- `br_taken` is forced to 0 outside RUN.
- Bypass:
  - `bypass_alu_1` = IR_Exec is ALU and `IR` is ALU/store/LDR/JMP and `IR[8:6]` == `IR_Exec[11:9]`.
  - `bypass_alu_2` = IR_Exec is ALU and `IR` is ADD/AND with `IR[5]` = 0 and `IR[2:0]` == `IR_Exec[11:9]`.
- Priority in RUN: `complete_instr` = 0 stall > memory entry > branch.

## Timing
- Reset values: every enable 0, `mem_state` 3, state STARTUP, ramp counter 0.
- Combinational outputs during reset: `br_taken` and bypass flags are 0.
- First edge with `reset` low gives `enable_fetch` = 1. Full pipeline is enabled 4 cycles after reset release.
- Memory-op latency:
  - 1 edge to park the pipeline.
  - Wait is unbounded; the controller stays in MEM_IND/MEM_RW for as long as `complete_data` is low.
  - `complete_data` high in MEM_RW resumes the pipeline on the next edge.
  - `complete_data` is ignored outside MEM_IND/MEM_RW.
- Reset asserted in any state gives reset values on the next edge; no pending memory op survives.
- A branch and a memory op cannot coexist in IR_Exec. A memory op takes precedence only by opcode; there is no tie case.

## Configuration
- `LC3_CTRL_BYPASS_EN`:
  - Defined: the bypass flags are computed as above.
  - Undefined: `bypass_alu_1` and `bypass_alu_2` are tied to 0 and no hazard stall is added. Software must space dependent instructions.
- All other behaviour is identical in both builds.

## Test plan
- Startup:
  - Stimulus: release reset with `complete_instr` = 1.
  - Required response: enables rise fetch, decode, execute, writeback on cycles 1, 2, 3, 4 after reset release; `mem_state` stays 3.
- LDR:
  - Stimulus: `IR_Exec` = 16'h6283 in RUN; `complete_data` high 3 cycles later.
  - Required response: all enables 0 with `mem_state` = 0 for 3 cycles; next edge, enables 1 (writeback 1) and `mem_state` = 3.
- STI:
  - Stimulus: `IR_Exec` = 16'hB201; `complete_data` pulses at cycles 2 and 4.
  - Required response: `mem_state` sequence 2, 2, 1, 1, 3; writeback 0 on the resume cycle.
- Branch:
  - Stimulus: `IR_Exec` = 16'h0E05, `NZP` = 3'b010, `psr` = 3'b010.
  - Required response: `br_taken` = 1; decode/execute/writeback 0 for 2 cycles while fetch = 1.
  - Stimulus (not taken): same with `psr` = 3'b001.
  - Required response: `br_taken` = 0, no flush.
- Bypass:
  - Stimulus: `IR_Exec` = 16'h1042 (ADD R0), `IR` = 16'h1201 (ADD R1, R0, R1).
  - Required response: `bypass_alu_1` = 1 and `bypass_alu_2` = 0 with the macro defined; both 0 without it.
- Mid-operation reset:
  - Stimulus: assert `reset` in MEM_IND.
  - Required response: next edge gives all enables 0 and `mem_state` 3; the startup ramp restarts.

Source files
------------

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 five-stage pipeline controller: startup ramp, memory parking, branch flush, bypass selects.
// Optional build macro LC3_CTRL_BYPASS_EN enables the execute-to-decode bypass flags.
//
// state   | meaning
// STARTUP | ramp stage enables in order after reset
// RUN     | normal flow, stalls while instruction memory is not ready
// MEM_IND | LDI/STI indirect address read outstanding
// MEM_RW  | data read or write outstanding
// FLUSH   | two cycles of fetch-only after a taken branch

module lc3_pipe_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic [1:0]  mem_state,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2
);

`ifdef LC3_CTRL_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {STARTUP, RUN, MEM_IND, MEM_RW, FLUSH} state_t;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_WRITE = 2'd1;
    localparam logic [1:0] MS_IND   = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    state_t     state;
    logic [1:0] ramp_cnt;
    logic       flush_cnt;
    logic       op_store;
    logic [4:0] en;

    logic [3:0] op_x, op_d;
    logic       is_load_x, is_store_x, is_ind_x, is_mem_x, is_alu_x, br_cond;
    logic       src1_user_d, src2_reg_d;
    logic       unused_bits;

    assign op_x = IR_Exec[15:12];
    assign op_d = IR[15:12];

    assign is_load_x  = (op_x == 4'b0010) || (op_x == 4'b0110) || (op_x == 4'b1010);
    assign is_store_x = (op_x == 4'b0011) || (op_x == 4'b0111) || (op_x == 4'b1011);
    assign is_ind_x   = (op_x == 4'b1010) || (op_x == 4'b1011);
    assign is_mem_x   = is_load_x || is_store_x;
    assign is_alu_x   = (op_x == 4'b0001) || (op_x == 4'b0101) || (op_x == 4'b1001) || (op_x == 4'b1110);
    assign br_cond    = ((op_x == 4'b0000) && (|(NZP & psr))) || (op_x == 4'b1100);

    // Decode-stage instructions that read SR1 / BaseR from IR[8:6]
    assign src1_user_d = (op_d == 4'b0001) || (op_d == 4'b0101) || (op_d == 4'b1001) ||
                         (op_d == 4'b1110) || (op_d == 4'b0011) || (op_d == 4'b0111) ||
                         (op_d == 4'b1011) || (op_d == 4'b0110) || (op_d == 4'b1100);
    assign src2_reg_d  = ((op_d == 4'b0001) || (op_d == 4'b0101)) && !IR[5];

    assign br_taken     = !reset && (state == RUN) && br_cond;
    assign bypass_alu_1 = BYPASS_EN && !reset && is_alu_x && src1_user_d && (IR[8:6] == IR_Exec[11:9]);
    assign bypass_alu_2 = BYPASS_EN && !reset && is_alu_x && src2_reg_d && (IR[2:0] == IR_Exec[11:9]);

    assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

    assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = en;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= STARTUP;
            ramp_cnt  <= 2'd0;
            flush_cnt <= 1'b0;
            op_store  <= 1'b0;
            en        <= 5'b00000;
            mem_state <= MS_IDLE;
        end else begin
            case (state)
                STARTUP: begin
                    ramp_cnt <= ramp_cnt + 2'd1;
                    en       <= {2'b11, ramp_cnt >= 2'd1, ramp_cnt >= 2'd2, ramp_cnt == 2'd3};
                    if (ramp_cnt == 2'd3) state <= RUN;
                end
                RUN: begin
                    if (!complete_instr) begin
                        en <= 5'b00000;
                    end else if (enable_execute && is_mem_x) begin
                        en       <= 5'b00000;
                        op_store <= is_store_x;
                        if (is_ind_x) begin
                            state     <= MEM_IND;
                            mem_state <= MS_IND;
                        end else begin
                            state     <= MEM_RW;
                            mem_state <= is_store_x ? MS_WRITE : MS_READ;
                        end
                    end else if (br_cond) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b1;
                        en        <= 5'b11000;
                    end else begin
                        en <= 5'b11111;
                    end
                end
                MEM_IND: begin
                    if (complete_data) begin
                        state     <= MEM_RW;
                        mem_state <= op_store ? MS_WRITE : MS_READ;
                    end
                end
                MEM_RW: begin
                    if (complete_data) begin
                        state     <= RUN;
                        mem_state <= MS_IDLE;
                        en        <= {4'b1111, !op_store};
                    end
                end
                FLUSH: begin
                    // Down-counter: flush enables stay up for two cycles in total
                    if (flush_cnt == 1'b0) begin
                        state <= RUN;
                        en    <= 5'b11111;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Self-checking bench for lc3_pipe_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_lc3_pipe_ctrl;

`ifdef LC3_CTRL_BYPASS_EN
    localparam logic B = 1'b1;
`else
    localparam logic B = 1'b0;
`endif

    localparam logic [4:0] OFF = 5'b00000;
    localparam logic [4:0] R1  = 5'b11000;
    localparam logic [4:0] R2  = 5'b11100;
    localparam logic [4:0] R3  = 5'b11110;
    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] FL  = 5'b11000;
    localparam logic [4:0] STR = 5'b11110;

    typedef struct {
        logic        rst, ci, cd;
        logic [15:0] ir, irx;
        logic [2:0]  nzp, psr;
        logic        br, b1, b2;
        logic [4:0]  en;
        logic [1:0]  ms;
    } vec_t;

    typedef struct {
        logic [4:0] en;
        logic [1:0] ms;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, complete_instr, complete_data;
    logic [15:0] IR, IR_Exec;
    logic [2:0]  NZP, psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic [1:0]  mem_state;
    logic        br_taken, bypass_alu_1, bypass_alu_2;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    lc3_pipe_ctrl dut (
        .clock(clock), .reset(reset),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
        .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
        .enable_decode(enable_decode), .enable_execute(enable_execute),
        .enable_writeback(enable_writeback), .mem_state(mem_state),
        .br_taken(br_taken), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, ci, cd, input logic [15:0] ir, irx,
                                input logic [2:0] nzp, p, input logic br, b1, b2,
                                input logic [4:0] en, input logic [1:0] ms);
        vec_t v;
        v.rst = rst; v.ci = ci; v.cd = cd; v.ir = ir; v.irx = irx;
        v.nzp = nzp; v.psr = p; v.br = br; v.b1 = b1; v.b2 = b2;
        v.en = en; v.ms = ms;
        return v;
    endfunction

    // Drive at negedge, check combinational outputs, then check registered outputs after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        logic [4:0] got_en;
        @(negedge clock);
        reset = v.rst; complete_instr = v.ci; complete_data = v.cd;
        IR = v.ir; IR_Exec = v.irx; NZP = v.nzp; psr = v.psr;
        #1;
        n_checks++;
        if ({br_taken, bypass_alu_1, bypass_alu_2} === {v.br, v.b1, v.b2}) n_pass++;
        else $display("FAIL %s comb br/byp1/byp2 got %b%b%b want %b%b%b", tag,
                      br_taken, bypass_alu_1, bypass_alu_2, v.br, v.b1, v.b2);
        e.en = v.en; e.ms = v.ms;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        got_en = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
        n_checks++;
        if (got_en === e.en && mem_state === e.ms) n_pass++;
        else $display("FAIL %s enables/mem_state got %b/%0d want %b/%0d", tag,
                      got_en, mem_state, e.en, e.ms);
    endtask

    initial begin
        int n;
        reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
        IR = 16'h0; IR_Exec = 16'h0; NZP = 3'b000; psr = 3'b010;

        //                rst ci cd  IR        IR_Exec   NZP     psr     br  b1  b2  en   ms
        tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0E05, 3'b010, 3'b010, 0, 0, 0, OFF, 3));
        tbl.push_back(mk(1, 1, 1, 16'h1201, 16'h1042, 3'b000, 3'b010, 0, 0, 0, OFF, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, R1,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, R2,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, R3,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        // bypass patterns in RUN
        tbl.push_back(mk(0, 1, 0, 16'h1201, 16'h1042, 3'b000, 3'b010, 0, B, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h1440, 16'h1042, 3'b000, 3'b010, 0, 0, B, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h1420, 16'h1042, 3'b000, 3'b010, 0, B, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h7080, 16'h5400, 3'b000, 3'b010, 0, B, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h2080, 16'h5400, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        // stall, then LDR: no entry while execute was stalled
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, OFF, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h6283, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h6283, 3'b000, 3'b010, 0, 0, 0, OFF, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h6283, 3'b000, 3'b010, 0, 0, 0, OFF, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h6283, 3'b000, 3'b010, 0, 0, 0, OFF, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        // STI: mem_state 2,2,1,1,3 and no writeback on resume
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 2));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 2));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 1));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, STR, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        // LD: stall wins over memory entry
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h2000, 3'b000, 3'b010, 0, 0, 0, OFF, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h2000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h2000, 3'b000, 3'b010, 0, 0, 0, OFF, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3));
        // taken BR: flush two cycles, br_taken forced low in FLUSH
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0E05, 3'b010, 3'b010, 1, 0, 0, FL,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0E05, 3'b010, 3'b010, 0, 0, 0, FL,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0E05, 3'b010, 3'b010, 0, 0, 0, ALL, 3));
        // not taken, then JMP, then branch under stall
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0E05, 3'b010, 3'b001, 0, 0, 0, ALL, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'hC1C0, 3'b000, 3'b001, 1, 0, 0, FL,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b001, 0, 0, 0, FL,  3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b001, 0, 0, 0, ALL, 3));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0E05, 3'b100, 3'b100, 1, 0, 0, OFF, 3));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b100, 0, 0, 0, ALL, 3));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

        // LDI with long, random waits in both memory states
        step(mk(0, 1, 0, 16'h0, 16'hA000, 3'b000, 3'b010, 0, 0, 0, OFF, 2), "ldi_enter");
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++)
            step(mk(0, 1, 0, 16'h0, 16'hA000, 3'b000, 3'b010, 0, 0, 0, OFF, 2), "ldi_ind_wait");
        step(mk(0, 1, 1, 16'h0, 16'hA000, 3'b000, 3'b010, 0, 0, 0, OFF, 0), "ldi_to_rw");
        n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++)
            step(mk(0, 1, 0, 16'h0, 16'hA000, 3'b000, 3'b010, 0, 0, 0, OFF, 0), "ldi_rw_wait");
        step(mk(0, 1, 1, 16'h0, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3), "ldi_resume");

        // Reset while in MEM_IND, then the ramp restarts with complete_data ignored
        step(mk(0, 1, 0, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 2), "rst_sti_enter");
        step(mk(0, 1, 0, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 2), "rst_sti_wait");
        step(mk(1, 1, 0, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, OFF, 3), "rst_mid");
        step(mk(0, 1, 1, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, R1,  3), "rst_ramp1");
        step(mk(0, 1, 1, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, R2,  3), "rst_ramp2");
        step(mk(0, 1, 1, 16'h0, 16'hB201, 3'b000, 3'b010, 0, 0, 0, R3,  3), "rst_ramp3");
        step(mk(0, 1, 0, 16'h0, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3), "rst_ramp4");
        step(mk(0, 1, 0, 16'h0, 16'h0000, 3'b000, 3'b010, 0, 0, 0, ALL, 3), "rst_run");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
